// File: rtl/sopc_nios2_0_oci_dct_unpacker_if.sv
// ----------------------------------------------------------------------------
// sopc_nios2_0_oci_dct_unpacker_if
//   Bundles the packed DCT word input stream, the unpacked trace-entry output
//   stream, the flush request and the drop statistics of the DCT unpacker.
//
//   Signals
//     dct_valid / dct_ready      word handshake (source -> unpacker)
//     dct_buffer [29:0]          packed entries, entry k = dct_buffer[2k+1:2k]
//     dct_count  [3:0]           number of valid entries (0..15)
//     flush                      discard held word and pending entries
//     entry_valid / entry_ready  entry handshake (unpacker -> sink)
//     entry_data [1:0]           current trace entry
//     entry_last                 current entry is the last of its word
//     overflow                   sticky: a word was offered while not ready
//     drop_count                 saturating count of dropped words
//
//   Modports
//     slave  : the unpacker's view
//     master : the environment's view (word source, entry sink, control)
// ----------------------------------------------------------------------------
interface sopc_nios2_0_oci_dct_unpacker_if #(
    parameter int DROP_CNT_W = 8
);
    logic                  dct_valid;
    logic                  dct_ready;
    logic [29:0]           dct_buffer;
    logic [3:0]            dct_count;
    logic                  flush;
    logic                  entry_valid;
    logic                  entry_ready;
    logic [1:0]            entry_data;
    logic                  entry_last;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;

    modport slave (
        input  dct_valid, dct_buffer, dct_count, flush, entry_ready,
        output dct_ready, entry_valid, entry_data, entry_last, overflow, drop_count
    );

    modport master (
        output dct_valid, dct_buffer, dct_count, flush, entry_ready,
        input  dct_ready, entry_valid, entry_data, entry_last, overflow, drop_count
    );
endinterface

// File: rtl/sopc_nios2_0_oci_dct_unpacker.sv
// ----------------------------------------------------------------------------
// sopc_nios2_0_oci_dct_unpacker
//   Reader side of the OCI compressed-trace buffer. Takes a packed 30-bit word
//   holding up to 15 two-bit trace entries and emits them one per cycle, LSB
//   field first, on a valid/ready stream. Words offered while busy are dropped
//   and counted; flush discards everything in flight.
//
//   Ports
//     clk    single clock
//     reset  synchronous, active-high reset
//     bus    sopc_nios2_0_oci_dct_unpacker_if.slave (word in, entry out,
//            flush, overflow / drop_count statistics)
//
//   Parameters
//     DROP_CNT_W  width of the saturating dropped-word counter; must match
//                 the DROP_CNT_W of the connected interface
// ----------------------------------------------------------------------------
module sopc_nios2_0_oci_dct_unpacker #(
    parameter int DROP_CNT_W = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    sopc_nios2_0_oci_dct_unpacker_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [29:0]           shreg;
    logic [3:0]            rem;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_count_q;

    logic entry_fire;
    logic word_accept;
    logic word_drop;

    // Entry outputs come straight from state registers, so they are glitch-free
    // and take effect one cycle after the word is accepted.
    assign bus.entry_valid = (state == SHIFT);
    assign bus.entry_data  = shreg[1:0];
    assign bus.entry_last  = (state == SHIFT) && (rem == 4'd1);
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_count_q;

    assign entry_fire = bus.entry_valid && bus.entry_ready;

    // Ready again on the cycle the last entry leaves, so a waiting word reloads
    // the shift register with no bubble between words.
    assign bus.dct_ready = (state == IDLE) || (entry_fire && bus.entry_last);

    // Zero-count words are neither loaded nor treated as lost.
    assign word_accept = bus.dct_valid && bus.dct_ready && (bus.dct_count != 4'd0);
    assign word_drop   = bus.dct_valid && !bus.dct_ready && (bus.dct_count != 4'd0);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            rem          <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (bus.flush) begin
            // Flush drops the held word and any offered word; statistics kept.
            state <= IDLE;
            shreg <= '0;
            rem   <= '0;
        end else begin
            if (word_accept) begin
                state <= SHIFT;
                shreg <= bus.dct_buffer;
                rem   <= bus.dct_count;
            end else if (entry_fire) begin
                if (rem == 4'd1) begin
                    // Clearing here keeps entry_data at zero while idle and
                    // hides the unused high fields of the word.
                    state <= IDLE;
                    shreg <= '0;
                    rem   <= '0;
                end else begin
                    shreg <= {2'b00, shreg[29:2]};
                    rem   <= rem - 4'd1;
                end
            end

            if (word_drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != {DROP_CNT_W{1'b1}}) begin
                    drop_count_q <= drop_count_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sopc_nios2_0_oci_dct_unpacker.sv
// ----------------------------------------------------------------------------
// tb_sopc_nios2_0_oci_dct_unpacker
//   Drives two unpacker instances (8-bit and 2-bit drop counters) with the
//   same stimulus and compares them against a queue-based model: an accepted
//   word appends its entries to a queue, the head of the queue is the entry
//   on offer, and dropped words are tallied as a plain integer.
// ----------------------------------------------------------------------------
module tb_sopc_nios2_0_oci_dct_unpacker;

    logic clk;
    logic reset;

    sopc_nios2_0_oci_dct_unpacker_if #(.DROP_CNT_W(8)) bus_a ();
    sopc_nios2_0_oci_dct_unpacker_if #(.DROP_CNT_W(2)) bus_b ();

    sopc_nios2_0_oci_dct_unpacker #(.DROP_CNT_W(8)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sopc_nios2_0_oci_dct_unpacker #(.DROP_CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] data;
        bit         last;
    } entry_t;

    entry_t q[$];
    int     drops;
    int     n_total;
    int     n_passed;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic drive(input bit v, input logic [29:0] b, input logic [3:0] c,
                         input bit er, input bit fl);
        bus_a.dct_valid   = v;  bus_b.dct_valid   = v;
        bus_a.dct_buffer  = b;  bus_b.dct_buffer  = b;
        bus_a.dct_count   = c;  bus_b.dct_count   = c;
        bus_a.entry_ready = er; bus_b.entry_ready = er;
        bus_a.flush       = fl; bus_b.flush       = fl;
    endtask

    task automatic check_outputs(input string tag);
        int sat_a;
        int sat_b;
        sat_a = (drops > 255) ? 255 : drops;
        sat_b = (drops > 3) ? 3 : drops;
        check({tag, ".entry_valid"}, 32'(bus_a.entry_valid), 32'(q.size() != 0));
        check({tag, ".entry_data"},  32'(bus_a.entry_data),  (q.size() != 0) ? 32'(q[0].data) : 32'd0);
        check({tag, ".entry_last"},  32'(bus_a.entry_last),  (q.size() != 0) ? 32'(q[0].last) : 32'd0);
        check({tag, ".overflow"},    32'(bus_a.overflow),    32'(drops != 0));
        check({tag, ".drop_count"},  32'(bus_a.drop_count),  32'(sat_a));
        check({tag, ".b.entry_valid"}, 32'(bus_b.entry_valid), 32'(q.size() != 0));
        check({tag, ".b.overflow"},    32'(bus_b.overflow),    32'(drops != 0));
        check({tag, ".b.drop_count"},  32'(bus_b.drop_count),  32'(sat_b));
    endtask

    // One clock cycle: apply inputs just after a falling edge, check the
    // combinational ready, advance the model on the rising edge, then check
    // the registered outputs on the next falling edge.
    task automatic step(input string tag, input bit v, input logic [29:0] b,
                        input logic [3:0] c, input bit er, input bit fl);
        bit exp_ready;
        bit fire;
        drive(v, b, c, er, fl);
        #1;
        exp_ready = (q.size() == 0) || (er && q.size() == 1);
        fire      = (q.size() != 0) && er;
        check({tag, ".dct_ready"},   32'(bus_a.dct_ready), 32'(exp_ready));
        check({tag, ".b.dct_ready"}, 32'(bus_b.dct_ready), 32'(exp_ready));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (v && c != 4'd0) begin
                if (exp_ready) begin
                    for (int k = 0; k < int'(c); k++) begin
                        entry_t e;
                        e.data = 2'((b >> (2 * k)) & 30'd3);
                        e.last = (k == int'(c) - 1);
                        q.push_back(e);
                    end
                end else begin
                    drops++;
                end
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        drops = 0;
        @(negedge clk);
        reset = 1'b0;
        check_outputs(tag);
        check({tag, ".dct_ready"}, 32'(bus_a.dct_ready), 32'd1);
    endtask

    // Consume entries with entry_ready high until the model queue is empty.
    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) step(tag, 1'b0, '0, '0, 1'b1, 1'b0);
        check({tag, ".drained"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        n_total  = 0;
        n_passed = 0;
        drops    = 0;
        reset    = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state, then a 4-entry word: entries 0,1,2,3 with last on the 4th.
        do_reset("reset");
        step("t1.accept", 1'b1, 30'h0000_00E4, 4'd4, 1'b1, 1'b0);
        check("t1.first_entry", 32'(bus_a.entry_data), 32'd0);
        drain("t1");

        // Back-to-back 15 and 2 entry words; second is offered until accepted.
        step("t2.w0", 1'b1, 30'h2AB1_C3D5, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !(q.size() == 1); i++)
            step("t2.run", 1'b0, '0, '0, 1'b1, 1'b0);
        step("t2.w1", 1'b1, 30'h0000_0007, 4'd2, 1'b1, 1'b0);
        check("t2.reload_head", 32'(bus_a.entry_data), 32'd3);
        drain("t2");

        // Stall for 5 cycles mid-word, drop one word during the stall.
        step("t3.load", 1'b1, 30'h0000_9C6B, 4'd8, 1'b1, 1'b0);
        step("t3.run",  1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step("t3.stall", (i == 2), 30'h3FFF_FFFF, 4'd9, 1'b0, 1'b0);
        check("t3.drop_count", 32'(bus_a.drop_count), 32'd1);
        drain("t3");

        // Five more drops: 8-bit counter reaches 6, 2-bit counter sticks at 3.
        step("t4.load", 1'b1, 30'h1234_5678, 4'd12, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("t4.drop", 1'b1, 30'(i), 4'd1, 1'b0, 1'b0);
        check("t4.sat", 32'(bus_b.drop_count), 32'd3);
        drain("t4");

        // Zero-count word while idle, then flush mid-word with a word offered.
        step("t5.zero", 1'b1, 30'h3FFF_FFFF, 4'd0, 1'b1, 1'b0);
        step("t5.load", 1'b1, 30'h0ABC_DEF1, 4'd6, 1'b1, 1'b0);
        step("t5.run",  1'b0, '0, '0, 1'b1, 1'b0);
        step("t5.flush", 1'b1, 30'h0000_0FFF, 4'd5, 1'b1, 1'b1);
        check("t5.flushed", 32'(bus_a.entry_valid), 32'd0);
        step("t5.idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Reset with 7 entries left.
        step("t6.load", 1'b1, 30'h3A5C_96E1, 4'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("t6.run", 1'b0, '0, '0, 1'b1, 1'b0);
        check("t6.left", 32'(q.size()), 32'd7);
        do_reset("t6.reset");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 2) != 0),
                 30'($urandom),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0));
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
